prog_sequencer: RTL and testbench

Run controller that sits directly upstream of the processor top level. It drives the core's `Start` and `Start_Addr` inputs and runs a fixed table of programs back to back. For each program it holds the core in its start condition, releases it, and waits for the core's halt indication or a watchdog timeout. It also reports the cycle count of every run for the test harness.

---
 rtl/prog_sequencer.sv | 138 +++++++++++++
 tb/tb_prog_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller in front of the core. It walks a fixed table
// of program start addresses. For each entry it holds the core in Start for
// START_LEN cycles, releases it, and waits for Halt or the watchdog. It then
// parks the core for one cycle and moves on to the next entry.
//
// Ports:
//   CLK, RST_N   clock / asynchronous active-low reset
//   Go           run the whole table (sampled in IDLE and DONE only)
//   StartTable   packed start addresses, entry i at [i*ADDR_W +: ADDR_W]
//   Halt         core finished the current program (sampled in RUN only)
//   Start        hold-in-start to the core (low only in RUN)
//   Start_Addr   start address of the current program
//   ProgIdx      index of the current / most recent program
//   Busy, Done   pass in progress / pass complete
//   LastCycles   RUN-cycle count of the last finished program
//   TimedOut     sticky watchdog flag for the current pass
module prog_sequencer #(
  parameter int          NUM_PROGS = 3,
  parameter int          ADDR_W    = 8,
  parameter int          START_LEN = 2,
  parameter logic [15:0] TIMEOUT   = 16'd4000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          Go,
  input  logic [NUM_PROGS*ADDR_W-1:0]   StartTable,
  input  logic                          Halt,
  output logic                          Start,
  output logic [ADDR_W-1:0]             Start_Addr,
  output logic [2:0]                    ProgIdx,
  output logic                          Busy,
  output logic                          Done,
  output logic [15:0]                   LastCycles,
  output logic                          TimedOut
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_DONE} state_t;

  localparam int LW = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [LW-1:0]   lcnt, lcnt_n;
  logic [15:0]     cyc, cyc_n, cyc_inc;
  logic [15:0]     last, last_n;
  logic            tout, tout_n;

  // Table padded to 8 entries so the 3-bit index always selects in range.
  logic [ADDR_W-1:0] tbl [8];
  for (genvar i = 0; i < 8; i++) begin : g_tbl
    if (i < NUM_PROGS) begin : g_used
      assign tbl[i] = StartTable[i*ADDR_W +: ADDR_W];
    end else begin : g_pad
      assign tbl[i] = '0;
    end
  end

  // Saturating RUN counter; the count reported is always this value.
  assign cyc_inc = (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    lcnt_n  = lcnt;
    cyc_n   = cyc;
    last_n  = last;
    tout_n  = tout;
    case (state)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_n = S_LAUNCH;
          idx_n   = 3'd0;
          lcnt_n  = '0;
          last_n  = 16'd0;
          tout_n  = 1'b0;
        end
      end
      S_LAUNCH: begin
        if (lcnt == LW'(START_LEN-1)) begin
          state_n = S_RUN;
          cyc_n   = 16'd0;
        end else begin
          lcnt_n = lcnt + 1'b1;
        end
      end
      S_RUN: begin
        cyc_n = cyc_inc;
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (Halt) begin
          last_n  = cyc_inc;
          state_n = S_NEXT;
        end else if (cyc_inc == TIMEOUT) begin
          last_n  = TIMEOUT;
          tout_n  = 1'b1;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx == 3'(NUM_PROGS-1)) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + 3'd1;
          lcnt_n  = '0;
          state_n = S_LAUNCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      idx   <= 3'd0;
      lcnt  <= '0;
      cyc   <= 16'd0;
      last  <= 16'd0;
      tout  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      lcnt  <= lcnt_n;
      cyc   <= cyc_n;
      last  <= last_n;
      tout  <= tout_n;
    end
  end

  // Everything below is decoded from registers only.
  assign Start      = (state != S_RUN);
  assign Busy       = (state == S_LAUNCH) || (state == S_RUN) || (state == S_NEXT);
  assign Done       = (state == S_DONE);
  assign ProgIdx    = idx;
  assign Start_Addr = tbl[idx];
  assign LastCycles = last;
  assign TimedOut   = tout;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a timeline model builds, per pass, the expected
// output record of every cycle from the per-program halt plan, and one
// compare step checks all outputs against it each cycle. Directed passes pin
// the model with hand-computed sequences; a random phase follows.
module tb_prog_sequencer;

  localparam int          NP = 3;
  localparam int          AW = 8;
  localparam int          SL = 2;
  localparam int          TO = 20;
  localparam int          TW = NP*AW;

  logic          CLK, RST_N, Go, Halt;
  logic [TW-1:0] table_r;
  logic          Start, Busy, Done, TimedOut;
  logic [AW-1:0] Start_Addr;
  logic [2:0]    ProgIdx;
  logic [15:0]   LastCycles;

  prog_sequencer #(.NUM_PROGS(NP), .ADDR_W(AW), .START_LEN(SL), .TIMEOUT(16'(TO))) dut (
    .CLK(CLK), .RST_N(RST_N), .Go(Go), .StartTable(table_r), .Halt(Halt),
    .Start(Start), .Start_Addr(Start_Addr), .ProgIdx(ProgIdx), .Busy(Busy),
    .Done(Done), .LastCycles(LastCycles), .TimedOut(TimedOut)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        start;
    logic [2:0]  idx;
    logic        busy;
    logic        done;
    logic [15:0] last;
    logic        to;
    int          run_k;    // k-th RUN cycle, 0 outside RUN
    int          halt_at;  // RUN cycle on which the core halts this program
  } rec_t;

  rec_t    q[$];
  rec_t    exp_cur;
  rec_t    idle_rec;
  int      plan [NP];
  int      ntests = 0;
  int      nfail  = 0;
  int      lc_seen[$];
  int      addr_seen[$];
  logic [15:0] prev_lc;
  logic        prev_start;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [2:0] i);
    logic [TW-1:0] t;
    int            b;
    t = table_r;
    b = int'(i) * AW;
    return t[b +: AW];
  endfunction

  // Whole-pass timeline: SL launch cycles, min(plan,TO) run cycles, one park
  // cycle per program, then the DONE record that persists.
  task automatic build();
    rec_t        r;
    logic [15:0] lst;
    logic        tof;
    int          len;
    lst = 16'd0;
    tof = 1'b0;
    for (int p = 0; p < NP; p++) begin
      len = (plan[p] < TO) ? plan[p] : TO;
      r = '{start:1'b1, idx:3'(p), busy:1'b1, done:1'b0, last:lst, to:tof,
            run_k:0, halt_at:plan[p]};
      repeat (SL) q.push_back(r);
      for (int k = 1; k <= len; k++) begin
        r.start = 1'b0;
        r.run_k = k;
        q.push_back(r);
      end
      lst = 16'(len);
      if (plan[p] > TO) tof = 1'b1;
      r.start = 1'b1; r.run_k = 0; r.last = lst; r.to = tof;
      q.push_back(r);
    end
    r.busy = 1'b0;
    r.done = 1'b1;
    q.push_back(r);
  endtask

  task automatic compare();
    chk("Start",      32'(Start),      32'(exp_cur.start));
    chk("Start_Addr", 32'(Start_Addr), 32'(addr_of(exp_cur.idx)));
    chk("ProgIdx",    32'(ProgIdx),    32'(exp_cur.idx));
    chk("Busy",       32'(Busy),       32'(exp_cur.busy));
    chk("Done",       32'(Done),       32'(exp_cur.done));
    chk("LastCycles", 32'(LastCycles), 32'(exp_cur.last));
    chk("TimedOut",   32'(TimedOut),   32'(exp_cur.to));
    if (LastCycles != prev_lc && LastCycles != 16'd0) lc_seen.push_back(int'(LastCycles));
    if (prev_start && !Start) addr_seen.push_back(int'(Start_Addr));
    prev_lc    = LastCycles;
    prev_start = Start;
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, check at the next falling edge.
  task automatic step(input bit go_i, input bit junk);
    Go = go_i;
    if (exp_cur.run_k != 0) Halt = (exp_cur.run_k == exp_cur.halt_at);
    else                    Halt = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge CLK);
    if (q.size() > 0) exp_cur = q.pop_front();
    else if (go_i) begin
      build();
      exp_cur = q.pop_front();
    end
    @(negedge CLK);
    Go   = 1'b0;
    Halt = 1'b0;
    compare();
  endtask

  task automatic run_pass(input int k0, input int k1, input int k2,
                          input bit junk, input bit go_mid);
    plan[0] = k0; plan[1] = k1; plan[2] = k2;
    lc_seen.delete();
    addr_seen.delete();
    step(1'b1, junk);
    for (int i = 0; i < 100 && !exp_cur.done; i++)
      step(go_mid && exp_cur.run_k == 2, junk);
    step(1'b0, junk);
  endtask

  task automatic chk_seq(input string nm, input int got[$], input int e0, input int e1, input int e2);
    int ev [3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    chk({nm, "_count"}, 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk(nm, 32'(got[i]), 32'(ev[i]));
  endtask

  task automatic chk_end(input int idx, input int to);
    chk("end_Done",     32'(Done),     32'd1);
    chk("end_ProgIdx",  32'(ProgIdx),  32'(idx));
    chk("end_TimedOut", 32'(TimedOut), 32'(to));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    RST_N   = 1'b0;
    Go      = 1'b0;
    Halt    = 1'b0;
    table_r = {8'h80, 8'h40, 8'h00};
    idle_rec = '{start:1'b1, idx:3'd0, busy:1'b0, done:1'b0, last:16'd0, to:1'b0,
                 run_k:0, halt_at:0};
    exp_cur    = idle_rec;
    prev_lc    = 16'd0;
    prev_start = 1'b1;
    repeat (3) @(negedge CLK);
    compare();
    RST_N = 1'b1;

    // Reset then idle, no Go.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      chk("idle_Start", 32'(Start), 32'd1);
      chk("idle_Busy",  32'(Busy),  32'd0);
      chk("idle_Done",  32'(Done),  32'd0);
      chk("idle_LC",    32'(LastCycles), 32'd0);
    end

    // Normal pass.
    run_pass(5, 7, 9, 1'b0, 1'b0);
    chk_seq("norm_addr", addr_seen, 'h00, 'h40, 'h80);
    chk_seq("norm_lc",   lc_seen,   5, 7, 9);
    chk_end(2, 0);

    // Ignored inputs: Go mid-RUN, junk Halt outside RUN.
    run_pass(5, 7, 9, 1'b1, 1'b1);
    chk_seq("ign_addr", addr_seen, 'h00, 'h40, 'h80);
    chk_seq("ign_lc",   lc_seen,   5, 7, 9);
    chk_end(2, 0);

    // Watchdog on program 1.
    run_pass(6, 99, 4, 1'b0, 1'b0);
    chk_seq("wd_addr", addr_seen, 'h00, 'h40, 'h80);
    chk_seq("wd_lc",   lc_seen,   6, 20, 4);
    repeat (5) step(1'b0, 1'b1);
    chk_end(2, 1);

    // Halt coincides with the watchdog.
    run_pass(20, 3, 5, 1'b0, 1'b0);
    chk_seq("coll_lc", lc_seen, 20, 3, 5);
    chk_end(2, 0);

    // Asynchronous reset mid-RUN of program 1.
    plan[0] = 3; plan[1] = 15; plan[2] = 4;
    step(1'b1, 1'b0);
    for (int i = 0; i < 60 && !(exp_cur.idx == 3'd1 && exp_cur.run_k == 5); i++)
      step(1'b0, 1'b0);
    chk("pre_rst_Start", 32'(Start), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_Start",   32'(Start),   32'd1);
    chk("rst_ProgIdx", 32'(ProgIdx), 32'd0);
    chk("rst_Busy",    32'(Busy),    32'd0);
    chk("rst_LC",      32'(LastCycles), 32'd0);
    q.delete();
    exp_cur    = idle_rec;
    prev_lc    = 16'd0;
    prev_start = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    run_pass(4, 5, 6, 1'b0, 1'b0);
    chk_seq("rst_addr", addr_seen, 'h00, 'h40, 'h80);
    chk_seq("rst_lc",   lc_seen,   4, 5, 6);

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      bit g;
      if (q.size() == 0) begin
        g = ($urandom_range(0, 3) == 0);
        if (g) for (int p = 0; p < NP; p++) plan[p] = int'($urandom_range(1, 24));
      end else begin
        g = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 15) == 0) table_r = TW'($urandom);
      step(g, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
